// File: rtl/decode_execute_latch_p_if.sv
// Decode->execute bundle channel: upstream valid/ready, downstream valid/ready, flush and halt status.
// Latency: none (signal bundle only).
// Backpressure: carries in_ready/out_ready; the latch owns the policy.
//
// Ports (slave = latch view):
//   flush, in_valid, rdat1_i/rdat2_i/imm_i/laddr_i, wsel_i, op_i, ctrl_i, out_ready  -> into latch
//   in_ready, out_valid, rdat1_o/rdat2_o/imm_o/laddr_o, wsel_o, op_o, ctrl_o, halt_o -> out of latch
interface decode_execute_latch_p_if #(
  parameter int DATA_W    = 32,
  parameter int REG_SEL_W = 5,
  parameter int OP_W      = 4
);
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_W-1:0]    rdat1_i, rdat2_i, imm_i, laddr_i;
  logic [REG_SEL_W-1:0] wsel_i;
  logic [OP_W-1:0]      op_i;
  logic [9:0]           ctrl_i;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_W-1:0]    rdat1_o, rdat2_o, imm_o, laddr_o;
  logic [REG_SEL_W-1:0] wsel_o;
  logic [OP_W-1:0]      op_o;
  logic [9:0]           ctrl_o;
  logic                 halt_o;

  modport slave (
    input  flush, in_valid, rdat1_i, rdat2_i, imm_i, laddr_i, wsel_i, op_i, ctrl_i, out_ready,
    output in_ready, out_valid, rdat1_o, rdat2_o, imm_o, laddr_o, wsel_o, op_o, ctrl_o, halt_o
  );

  modport master (
    output flush, in_valid, rdat1_i, rdat2_i, imm_i, laddr_i, wsel_i, op_i, ctrl_i, out_ready,
    input  in_ready, out_valid, rdat1_o, rdat2_o, imm_o, laddr_o, wsel_o, op_o, ctrl_o, halt_o
  );
endinterface

// File: rtl/decode_execute_latch_p.sv
// Decode->execute pipeline latch with flush-to-bubble, sticky halt and optional 2-entry skid buffer.
// Latency: 1 cycle from accept to out_valid.
// Backpressure: SKID=1 registered in_ready (= no skid entry held); SKID=0 in_ready = ~out_valid | out_ready.
//
// Ports: CLK, RST (async, active-high) plain; everything else on bus (slave modport):
//   bus.in_*/bundle *_i  decode side,  bus.out_*/bundle *_o  execute side,
//   bus.flush squashes held entries, bus.halt_o sticky halt-seen flag.
module decode_execute_latch_p #(
  parameter int DATA_W    = 32,
  parameter int REG_SEL_W = 5,
  parameter int OP_W      = 4,
  parameter int SKID      = 1
) (
  input  logic CLK,
  input  logic RST,
  decode_execute_latch_p_if.slave bus
);

  // ctrl bit order: [0]dREN [1]dWEN [2]reg_wr [3]beq [4]bne [5]jrsig
  //                 [6]immSig [7]write_sig [8]halt [9]pcAddrOut
  localparam int HALT_BIT = 8;

  typedef struct packed {
    logic [9:0]           ctrl;
    logic [OP_W-1:0]      op;
    logic [REG_SEL_W-1:0] wsel;
    logic [DATA_W-1:0]    laddr;
    logic [DATA_W-1:0]    imm;
    logic [DATA_W-1:0]    rdat2;
    logic [DATA_W-1:0]    rdat1;
  } bundle_t;

  bundle_t in_b;
  bundle_t main_q;
  bundle_t skid_q;
  logic    main_vld;
  logic    skid_vld;
  logic    halt_q;
  logic    in_ready_w;
  logic    accept;
  logic    drain;

  assign in_b.ctrl  = bus.ctrl_i;
  assign in_b.op    = bus.op_i;
  assign in_b.wsel  = bus.wsel_i;
  assign in_b.laddr = bus.laddr_i;
  assign in_b.imm   = bus.imm_i;
  assign in_b.rdat2 = bus.rdat2_i;
  assign in_b.rdat1 = bus.rdat1_i;

  // With the skid buffer in_ready depends only on flops, so decode never sees
  // a combinational path from out_ready. Without it, accept when the slot is
  // free or is being emptied this cycle.
  assign in_ready_w = (SKID != 0) ? (~skid_vld & ~halt_q)
                                  : ((~main_vld | bus.out_ready) & ~halt_q);

  assign accept = bus.in_valid & in_ready_w;
  assign drain  = main_vld & bus.out_ready;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      halt_q   <= 1'b0;
    end else begin
      // A flushed bundle never enters the latch, so it cannot raise halt.
      if (accept && in_b.ctrl[HALT_BIT] && !bus.flush) begin
        halt_q <= 1'b1;
      end

      if (bus.flush) begin
        main_vld <= 1'b0;
        skid_vld <= 1'b0;
      end else if (SKID != 0) begin
        if (!main_vld || drain) begin
          if (skid_vld) begin
            // Older skid entry moves up first to keep FIFO order.
            main_q   <= skid_q;
            main_vld <= 1'b1;
            skid_vld <= accept;
            if (accept) begin
              skid_q <= in_b;
            end
          end else begin
            main_vld <= accept;
            if (accept) begin
              main_q <= in_b;
            end
          end
        end else if (accept) begin
          // Main is stalled: park the bundle accepted under the registered ready.
          skid_q   <= in_b;
          skid_vld <= 1'b1;
        end
      end else begin
        if (accept) begin
          main_q   <= in_b;
          main_vld <= 1'b1;
        end else if (drain) begin
          main_vld <= 1'b0;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = main_vld;
  assign bus.rdat1_o   = main_q.rdat1;
  assign bus.rdat2_o   = main_q.rdat2;
  assign bus.imm_o     = main_q.imm;
  assign bus.laddr_o   = main_q.laddr;
  assign bus.wsel_o    = main_q.wsel;
  assign bus.op_o      = main_q.op;
  // Bubbles carry no control so no write, branch or memory request can leak.
  assign bus.ctrl_o    = main_vld ? main_q.ctrl : 10'h000;
  assign bus.halt_o    = halt_q;

endmodule

// File: tb/tb_decode_execute_latch_p.sv
module tb_decode_execute_latch_p;

  logic CLK;
  logic RST;
  int   checks;
  int   failures;

  decode_execute_latch_p_if #(.DATA_W(32), .REG_SEL_W(5), .OP_W(4)) b1 ();
  decode_execute_latch_p_if #(.DATA_W(32), .REG_SEL_W(5), .OP_W(4)) b0 ();

  decode_execute_latch_p #(.DATA_W(32), .REG_SEL_W(5), .OP_W(4), .SKID(1)) dut_skid (
    .CLK(CLK), .RST(RST), .bus(b1)
  );

  decode_execute_latch_p #(.DATA_W(32), .REG_SEL_W(5), .OP_W(4), .SKID(0)) dut_noskid (
    .CLK(CLK), .RST(RST), .bus(b0)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set1(input logic v, input logic [31:0] r1, input logic [3:0] op, input logic [9:0] ctrl);
    b1.in_valid = v;
    b1.rdat1_i  = r1;
    b1.rdat2_i  = ~r1;
    b1.imm_i    = 32'h1000 + r1;
    b1.laddr_i  = r1 << 2;
    b1.wsel_i   = r1[4:0];
    b1.op_i     = op;
    b1.ctrl_i   = ctrl;
  endtask

  task automatic set0(input logic v, input logic [31:0] r1);
    b0.in_valid = v;
    b0.rdat1_i  = r1;
    b0.rdat2_i  = 32'h0;
    b0.imm_i    = 32'h0;
    b0.laddr_i  = 32'h0;
    b0.wsel_i   = 5'd0;
    b0.op_i     = 4'h1;
    b0.ctrl_i   = 10'h004;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    RST      = 1'b1;
    set1(1'b0, 32'h0, 4'h0, 10'h000);
    b1.flush     = 1'b0;
    b1.out_ready = 1'b0;
    set0(1'b0, 32'h0);
    b0.flush     = 1'b0;
    b0.out_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_in_ready", b1.in_ready, 1);
    chk("rst_out_valid", b1.out_valid, 0);
    chk("rst_ctrl_o", b1.ctrl_o, 0);
    chk("rst_halt_o", b1.halt_o, 0);
    chk("rst_rdat1_o", b1.rdat1_o, 0);
    chk("rst_ns_in_ready", b0.in_ready, 1);
    tick();
    RST = 1'b0;
    chk("post_rst_in_ready", b1.in_ready, 1);

    // Streaming 8 bundles back-to-back
    b1.out_ready = 1'b1;
    set1(1'b1, 32'd1, 4'h1, 10'h004);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("stream_out_valid", b1.out_valid, 1);
      chk("stream_rdat1_o", b1.rdat1_o, i);
      chk("stream_imm_o", b1.imm_o, 32'h1000 + i);
      chk("stream_ctrl_o", b1.ctrl_o, 10'h004);
      chk("stream_in_ready", b1.in_ready, 1);
      if (i < 8) set1(1'b1, i + 1, 4'h1, 10'h004);
      else       set1(1'b0, 32'd0, 4'h0, 10'h000);
    end
    tick();
    chk("stream_bubble_valid", b1.out_valid, 0);
    chk("stream_bubble_ctrl", b1.ctrl_o, 0);
    chk("stream_bubble_hold", b1.rdat1_o, 8);

    // Back-pressure: A then B, execute stalled
    b1.out_ready = 1'b0;
    set1(1'b1, 32'h0A, 4'h2, 10'h004);
    tick();
    chk("bp_a_valid", b1.out_valid, 1);
    chk("bp_a_op", b1.op_o, 4'h2);
    set1(1'b1, 32'h0B, 4'h6, 10'h004);
    tick();
    chk("bp_in_ready_full", b1.in_ready, 0);
    chk("bp_op_after_b", b1.op_o, 4'h2);
    set1(1'b0, 32'h0, 4'h0, 10'h000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_stall_op", b1.op_o, 4'h2);
      chk("bp_stall_rdat1", b1.rdat1_o, 32'h0A);
      chk("bp_stall_valid", b1.out_valid, 1);
      chk("bp_stall_in_ready", b1.in_ready, 0);
    end
    b1.out_ready = 1'b1;
    tick();
    chk("bp_b_op", b1.op_o, 4'h6);
    chk("bp_b_rdat1", b1.rdat1_o, 32'h0B);
    chk("bp_b_valid", b1.out_valid, 1);
    chk("bp_in_ready_back", b1.in_ready, 1);
    tick();
    chk("bp_drained", b1.out_valid, 0);

    // Async reset while holding a valid bundle
    b1.out_ready = 1'b0;
    set1(1'b1, 32'h33, 4'h3, 10'h004);
    tick();
    set1(1'b0, 32'h0, 4'h0, 10'h000);
    chk("arst_pre_valid", b1.out_valid, 1);
    #1;
    RST = 1'b1;
    #1;
    chk("arst_valid", b1.out_valid, 0);
    chk("arst_ctrl", b1.ctrl_o, 0);
    chk("arst_rdat1", b1.rdat1_o, 0);
    tick();
    RST = 1'b0;
    chk("arst_in_ready", b1.in_ready, 1);

    // Flush with main and skid both valid
    set1(1'b1, 32'hC0, 4'h3, 10'h004);
    tick();
    set1(1'b1, 32'hD0, 4'h4, 10'h004);
    tick();
    chk("fl_full_in_ready", b1.in_ready, 0);
    chk("fl_pre_ctrl", b1.ctrl_o, 10'h004);
    set1(1'b1, 32'hEE, 4'h5, 10'h004);
    b1.flush = 1'b1;
    tick();
    chk("fl_valid", b1.out_valid, 0);
    chk("fl_ctrl", b1.ctrl_o, 0);
    chk("fl_in_ready", b1.in_ready, 1);
    // Flush beats an accept that is allowed this cycle
    tick();
    b1.flush = 1'b0;
    set1(1'b0, 32'h0, 4'h0, 10'h000);
    b1.out_ready = 1'b1;
    chk("fl_accept_dropped", b1.out_valid, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fl_no_ghost", b1.out_valid, 0);
    end

    // Halt capture
    b1.out_ready = 1'b0;
    set1(1'b1, 32'h55, 4'h7, 10'h100);
    tick();
    chk("halt_set", b1.halt_o, 1);
    chk("halt_valid", b1.out_valid, 1);
    chk("halt_ctrl", b1.ctrl_o, 10'h100);
    chk("halt_in_ready", b1.in_ready, 0);
    set1(1'b1, 32'h66, 4'h8, 10'h004);
    b1.out_ready = 1'b1;
    tick();
    chk("halt_drained", b1.out_valid, 0);
    chk("halt_in_ready2", b1.in_ready, 0);
    set1(1'b0, 32'h0, 4'h0, 10'h000);
    b1.flush = 1'b1;
    tick();
    b1.flush = 1'b0;
    chk("halt_after_flush", b1.halt_o, 1);
    chk("halt_after_flush_rdy", b1.in_ready, 0);
    #1;
    RST = 1'b1;
    #1;
    chk("halt_cleared_rst", b1.halt_o, 0);
    tick();
    RST = 1'b0;
    chk("halt_rst_in_ready", b1.in_ready, 1);

    // SKID=0 build
    set0(1'b1, 32'h11);
    b0.out_ready = 1'b0;
    tick();
    chk("ns_valid", b0.out_valid, 1);
    chk("ns_rdat1", b0.rdat1_o, 32'h11);
    #1;
    chk("ns_in_ready_stall", b0.in_ready, 0);
    b0.out_ready = 1'b1;
    #1;
    chk("ns_in_ready_comb", b0.in_ready, 1);
    set0(1'b1, 32'h12);
    tick();
    chk("ns_rdat1_b", b0.rdat1_o, 32'h12);
    set0(1'b1, 32'h13);
    tick();
    chk("ns_rdat1_c", b0.rdat1_o, 32'h13);
    chk("ns_valid_c", b0.out_valid, 1);
    set0(1'b0, 32'h0);
    tick();
    chk("ns_drained", b0.out_valid, 0);
    chk("ns_ctrl_bubble", b0.ctrl_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_execute_latch_p.md
Name: decode_execute_latch_p

Overview:
- Parametrised successor to the fixed 32-bit decode/execute pipeline latch.
- Carries the decoded instruction bundle from decode to execute: operands, immediate, link address, write select, ALU op and control bits.
- Adds a valid/ready handshake, an optional 2-entry skid buffer for back-pressure, flush-to-bubble and a sticky halt capture.
- Sits between the decode stage and the ALU/execute stage in the pipelined datapath.

Parameters:
- DATA_W, 32, width of rdat1, rdat2, imm, laddr fields.
- REG_SEL_W, 5, width of the write-register select.
- OP_W, 4, width of the ALU opcode.
- SKID, 1, 1 = 2-entry skid buffer (registered in_ready); 0 = single register (combinational in_ready).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- flush  in  1  squash all held entries (branch/jump mispredict).
- in_valid  in  1  decode presents a bundle.
- in_ready  out  1  latch can accept this cycle.
- rdat1_i, rdat2_i, imm_i, laddr_i  in  DATA_W each  operand/immediate/link fields.
- wsel_i  in  REG_SEL_W  destination register.
- op_i  in  OP_W  ALU op.
- ctrl_i  in  10  control bits, in this bit order: [0]dREN [1]dWEN [2]reg_wr [3]beq [4]bne [5]jrsig [6]immSig [7]write_sig [8]halt [9]pcAddrOut.
- out_valid  out  1  execute-side bundle valid.
- out_ready  in  1  execute can consume.
- rdat1_o, rdat2_o, imm_o, laddr_o, wsel_o, op_o, ctrl_o  out  matching widths  registered bundle.
- halt_o  out  1  sticky: a halt instruction has entered the latch.

Behaviour:
- **Reset (async, RST=1):**
  - All valid bits, skid entry, data/ctrl outputs and halt_o cleared to 0.
  - in_ready=1 while RST=1 and the cycle after.
- **Transfer rules:**
  - Accept occurs when in_valid & in_ready.
  - Drain occurs when out_valid & out_ready.
- **Main register:**
  - Loads on accept when empty, or when draining in the same cycle.
  - If the skid buffer is valid, the main register reloads from skid (FIFO order) and the incoming bundle goes to skid.
- **SKID=1:**
  - in_ready = ~skid_valid (registered).
  - Accept while main valid and not draining → bundle goes to the skid buffer.
  - Throughput 1/cycle with zero bubbles when out_ready is steady high.
  - Latency 1 cycle from accept to out_valid.
- **SKID=0:** in_ready = ~out_valid | out_ready (combinational). No skid storage.
- **Bubble:**
  - When out_valid=0, ctrl_o is forced to 0 so no write, branch or memory request can leak.
  - Data fields hold their last value.
- **Flush:**
  - Next edge clears main and skid valid; ctrl_o=0.
  - Flush beats a simultaneous accept: the incoming bundle is dropped.
  - in_ready=1 the cycle after the flush (unless halted).
  - Flush does not clear halt_o.
- **Halt:**
  - On accept of a bundle with ctrl_i[8]=1, halt_o sets the next cycle and stays set until RST.
  - While halt_o=1, in_ready=0. The halt bundle itself still drains normally.
- **Stall (out_ready=0):** outputs hold bit-for-bit stable; no field may change while out_valid=1 & out_ready=0.
- **Simultaneous drain and accept with full skid:** not possible, since in_ready=0 when skid is full.
- **Reset mid-transfer:** all held entries are lost; no partial bundle survives.

Test Plan:
- **Reset:** assert RST mid-stream with out_valid=1 → out_valid=0, ctrl_o=0, halt_o=0 asynchronously; in_ready=1 after release.
- **Streaming, SKID=1:** 8 back-to-back bundles, rdat1_i=1..8, out_ready=1 → out_valid high from cycle 1, rdat1_o=1..8 in order, no gaps.
- **Back-pressure:**
  - Accept bundles A(op=4'h2), B(op=4'h6), then drop out_ready for 3 cycles → in_ready=0 after B, op_o stays 4'h2 stable.
  - Raise out_ready → A then B delivered, in_ready returns to 1.
- **Flush:**
  - Main and skid both valid, ctrl reg_wr=1, flush=1 with in_valid=1 → next cycle out_valid=0, ctrl_o=0, incoming bundle not seen later.
- **Halt:**
  - Accept bundle with ctrl_i=10'h100 → halt_o=1 next cycle, in_ready=0 afterwards.
  - Halt bundle appears on ctrl_o; a following flush leaves halt_o=1.
- **SKID=0 build:**
  - out_ready=0 with main valid → in_ready=0 combinationally.
  - out_ready=1 → in_ready=1 in the same cycle; one bundle per cycle passes.
